// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data_ram wait-state data memory.
// sel_legal is only referenced when DATA_RAM_SEL_CHECK_EN is defined.
package data_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_LANES = 64;
    localparam int unsigned CNT_W     = 4;

    function automatic int unsigned lane_count(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned offset_width(input int unsigned lanes);
        return (lanes <= 1) ? 0 : $clog2(lanes);
    endfunction

    // Legal strobe: all-zero, or one aligned, power-of-two-sized run of set lanes.
    function automatic logic sel_legal(input logic [MAX_LANES-1:0] sel);
        int unsigned          cnt;
        int unsigned          low;
        logic                 found;
        logic [MAX_LANES-1:0] run;
        cnt   = 0;
        low   = 0;
        found = 1'b0;
        run   = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (sel[i]) begin
                cnt = cnt + 1;
                if (!found) begin
                    low   = i;
                    found = 1'b1;
                end
            end
        end
        if (cnt == 0) begin
            return 1'b1;
        end
        for (int i = 0; i < MAX_LANES; i++) begin
            run[i] = (i >= low) && (i < low + cnt);
        end
        return (sel == run) && ((cnt & (cnt - 1)) == 0) && ((low & (cnt - 1)) == 0);
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Byte-enabled word storage with a single registered access port and no reset.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                    clock,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic                    re_i,
    input  logic [DEPTH_LOG2-1:0]   index_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH);
    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_i[i]) begin
                mem_q[index_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[index_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// data_ram: wait-state-capable data memory behind a request/response handshake.
// Optional write-strobe legality check enabled by DATA_RAM_SEL_CHECK_EN.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    chip_enable,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_select,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int unsigned LANES = lane_count(DATA_WIDTH);
    localparam int unsigned OFS   = offset_width(LANES);

    state_t                  state_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic                    rd_valid_q;

    logic                    accept_c;
    logic                    access_c;
    logic                    cnt_zero_c;
    logic                    acc_write_c;
    logic [DEPTH_LOG2-1:0]   acc_index_c;
    logic [DATA_WIDTH-1:0]   acc_wdata_c;
    logic [LANES-1:0]        acc_select_c;
    logic                    acc_err_c;
    logic [LANES-1:0]        arr_we_c;
    logic                    arr_re_c;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic                    addr_unused;

    // High address bits are dropped so addresses wrap onto the array.
    assign addr_unused = ^req_address;

    assign accept_c = reset_n && chip_enable && req_valid && (state_q != WAIT);

    if (WAIT_CYCLES == 0) begin : g_no_wait
        // Access happens at the accept edge, straight from the request inputs.
        assign acc_write_c  = req_write;
        assign acc_index_c  = req_address[DEPTH_LOG2+OFS-1:OFS];
        assign acc_wdata_c  = req_wdata;
        assign acc_select_c = req_select;
        assign access_c     = accept_c;
        assign cnt_zero_c   = 1'b1;
    end else begin : g_wait
        logic [CNT_W-1:0]      cnt_q;
        logic                  write_q;
        logic [DEPTH_LOG2-1:0] index_q;
        logic [DATA_WIDTH-1:0] wdata_q;
        logic [LANES-1:0]      select_q;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                cnt_q <= CNT_W'(WAIT_CYCLES - 1);
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end

        // Request payload is captured once; later input changes are ignored.
        always_ff @(posedge clock) begin
            if (accept_c) begin
                write_q  <= req_write;
                index_q  <= req_address[DEPTH_LOG2+OFS-1:OFS];
                wdata_q  <= req_wdata;
                select_q <= req_select;
            end
        end

        assign acc_write_c  = write_q;
        assign acc_index_c  = index_q;
        assign acc_wdata_c  = wdata_q;
        assign acc_select_c = select_q;
        assign cnt_zero_c   = (cnt_q == '0);
        assign access_c     = reset_n && (state_q == WAIT) && cnt_zero_c;
    end

`ifdef DATA_RAM_SEL_CHECK_EN
    assign acc_err_c = acc_write_c && !sel_legal(MAX_LANES'(acc_select_c));
`else
    assign acc_err_c = 1'b0;
`endif

    assign arr_we_c = (access_c && acc_write_c && !acc_err_c) ? acc_select_c : '0;
    assign arr_re_c = access_c && !acc_write_c;

    data_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock   (clock),
        .we_i    (arr_we_c),
        .re_i    (arr_re_c),
        .index_i (acc_index_c),
        .wdata_i (acc_wdata_c),
        .rdata_o (arr_rdata)
    );

    // Control FSM; response flags pulse for exactly the cycle after the access edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            resp_valid_q <= access_c;
            resp_err_q   <= access_c && acc_err_c;
            rd_valid_q   <= access_c && !acc_write_c;
            case (state_q)
                WAIT: begin
                    if (cnt_zero_c) begin
                        state_q     <= DONE;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (accept_c) begin
                        state_q     <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                        req_ready_q <= (WAIT_CYCLES == 0);
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rd_valid_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram: three instances with WAIT_CYCLES 0, 3 and 5.
module tb_data_ram;

    logic        clock;
    logic        reset_n     [3];
    logic        chip_enable [3];
    logic        req_valid   [3];
    logic        req_ready   [3];
    logic        req_write   [3];
    logic [31:0] req_address [3];
    logic [31:0] req_wdata   [3];
    logic [3:0]  req_select  [3];
    logic        resp_valid  [3];
    logic [31:0] resp_rdata  [3];
    logic        resp_err    [3];

    int n_checks = 0;
    int n_fail   = 0;
    int waits_of [3] = '{0, 3, 5};

    data_ram #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .reset_n(reset_n[0]), .chip_enable(chip_enable[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_address(req_address[0]), .req_wdata(req_wdata[0]), .req_select(req_select[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    data_ram #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
        .clock(clock), .reset_n(reset_n[1]), .chip_enable(chip_enable[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_address(req_address[1]), .req_wdata(req_wdata[1]), .req_select(req_select[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    data_ram #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(5)) u_w5 (
        .clock(clock), .reset_n(reset_n[2]), .chip_enable(chip_enable[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_address(req_address[2]), .req_wdata(req_wdata[2]), .req_select(req_select[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on instance d; returns response data, error flag and accept-to-response latency.
    task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clock);
        req_write[d]   = wr;
        req_address[d] = addr;
        req_wdata[d]   = wd;
        req_select[d]  = sel;
        req_valid[d]   = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        @(negedge clock);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        rdata = resp_rdata[d];
        err   = resp_err[d];
    endtask

    task automatic xfer(input string tag, input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(d, wr, addr, wd, sel, rd, er, lat);
        check_eq({tag, " latency"}, 32'(lat), 32'(waits_of[d] + 1));
        check_eq({tag, " rdata"}, rd, exp_rdata);
        check_eq({tag, " err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        int vcount;
        for (int d = 0; d < 3; d++) begin
            reset_n[d]     = 1'b0;
            chip_enable[d] = 1'b1;
            req_valid[d]   = 1'b0;
            req_write[d]   = 1'b0;
            req_address[d] = '0;
            req_wdata[d]   = '0;
            req_select[d]  = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 3; d++) reset_n[d] = 1'b1;

        // Reset state
        check_eq("rst ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst valid", 32'(resp_valid[0]), 32'd0);
        check_eq("rst rdata", resp_rdata[0], 32'd0);
        check_eq("rst err", 32'(resp_err[0]), 32'd0);
        check_eq("rst ready w3", 32'(req_ready[1]), 32'd1);

        // Zero-wait write then read
        xfer("w0 wr 10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        xfer("w0 rd 10", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        @(negedge clock);
        check_eq("rdata idle zero", resp_rdata[0], 32'd0);
        check_eq("valid one pulse", 32'(resp_valid[0]), 32'd0);

        // Byte-lane merge
        xfer("merge init", 0, 1'b1, 32'h10, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        xfer("merge b0", 0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        xfer("merge rd1", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'h112233AA, 1'b0);
        xfer("merge b3", 0, 1'b1, 32'h10, 32'hBB000000, 4'b1000, 32'h0, 1'b0);
        xfer("merge rd2", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hBB2233AA, 1'b0);

        // Select zero is a no-op write that still responds
        xfer("sel0 wr", 0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        xfer("sel0 rd", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hBB2233AA, 1'b0);

        // Address wrap at 4 KiB for 1024 words
        xfer("wrap wr", 0, 1'b1, 32'h1004, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        xfer("wrap rd", 0, 1'b0, 32'h0004, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

        // Non-aligned strobe 0110
        xfer("sel0110 init", 0, 1'b1, 32'h20, 32'hA1B2C3D4, 4'b1111, 32'h0, 1'b0);
`ifdef DATA_RAM_SEL_CHECK_EN
        xfer("sel0110 wr", 0, 1'b1, 32'h20, 32'h55667788, 4'b0110, 32'h0, 1'b1);
        xfer("sel0110 rd", 0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hA1B2C3D4, 1'b0);
        xfer("sel0011 wr", 0, 1'b1, 32'h20, 32'h55667788, 4'b0011, 32'h0, 1'b0);
        xfer("sel0011 rd", 0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hA1B27788, 1'b0);
`else
        xfer("sel0110 wr", 0, 1'b1, 32'h20, 32'h55667788, 4'b0110, 32'h0, 1'b0);
        xfer("sel0110 rd", 0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hA16677D4, 1'b0);
`endif

        // chip_enable low masks the request
        @(negedge clock);
        chip_enable[0] = 1'b0;
        req_write[0]   = 1'b0;
        req_valid[0]   = 1'b1;
        vcount = 0;
        repeat (3) begin
            @(negedge clock);
            if (resp_valid[0]) vcount++;
        end
        check_eq("ce low no resp", 32'(vcount), 32'd0);
        req_valid[0]   = 1'b0;
        chip_enable[0] = 1'b1;

        // WAIT_CYCLES=3 back-to-back reads with valid held high
        xfer("w3 wr 40", 1, 1'b1, 32'h40, 32'h40404040, 4'b1111, 32'h0, 1'b0);
        xfer("w3 wr 44", 1, 1'b1, 32'h44, 32'h44444444, 4'b1111, 32'h0, 1'b0);
        @(negedge clock);
        req_write[1]   = 1'b0;
        req_address[1] = 32'h40;
        req_valid[1]   = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            if (k == 1) req_address[1] = 32'h44;
            check_eq($sformatf("b2b ready k%0d", k), 32'(req_ready[1]), 32'((k % 4) == 0 || k == 9));
            check_eq($sformatf("b2b valid k%0d", k), 32'(resp_valid[1]), 32'((k % 4) == 0));
            if (k == 4) check_eq("b2b rdata 1", resp_rdata[1], 32'h40404040);
            if (k == 8) check_eq("b2b rdata 2", resp_rdata[1], 32'h44444444);
            if (k == 9) check_eq("b2b rdata idle", resp_rdata[1], 32'h0);
            if (k == 5) req_valid[1] = 1'b0;
        end

        // WAIT_CYCLES=5: reset at the second wait edge discards the pending write
        xfer("w5 wr old", 2, 1'b1, 32'h80, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0);
        @(negedge clock);
        req_write[2]   = 1'b1;
        req_address[2] = 32'h80;
        req_wdata[2]   = 32'h12345678;
        req_select[2]  = 4'b1111;
        req_valid[2]   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid[2] = 1'b0;
        @(negedge clock);
        reset_n[2] = 1'b0;
        @(negedge clock);
        reset_n[2] = 1'b1;
        check_eq("w5 rst ready", 32'(req_ready[2]), 32'd1);
        vcount = 0;
        repeat (8) begin
            if (resp_valid[2]) vcount++;
            @(negedge clock);
        end
        check_eq("w5 rst no resp", 32'(vcount), 32'd0);
        xfer("w5 rd old", 2, 1'b0, 32'h80, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
